uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 52080, is the number of clk cycles an owner may stay idle while holding the grant (10 bit times at 50 MHz / 9600 baud).
REQ-002 Parameter CNT_W, default 16, is the timeout counter width; IDLE_TIMEOUT SHALL be < 2^CNT_W.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 presents a byte.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_last  input  1  byte ends requester 0's message; grant is released after it is sent.
REQ-008 req0_ready  output  1  arbiter accepts requester 0's byte this cycle.
REQ-009 req1_valid / req1_data / req1_last / req1_ready  same widths and meanings for requester 1.
REQ-010 tx_start  output  1  one-cycle start pulse to the UART transmitter core.
REQ-011 tx_data  output  8  byte for the transmitter, registered.
REQ-012 tx_busy  input  1  transmitter is sending a frame.
REQ-013 grant  output  2  one-hot current owner (bit0 = req0, bit1 = req1); 2'b00 when unowned.
REQ-014 timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, OWN, START, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE, only req0_valid high: set grant=01 and go to OWN on the next cycle.
REQ-017 IDLE, only req1_valid high: set grant=10 and go to OWN on the next cycle.
REQ-018 IDLE, both valid: grant the requester that is not last_owner (round-robin), then go to OWN.
REQ-019 IDLE, neither valid: stay in IDLE with grant=00.
REQ-020 In OWN, the owner's ready SHALL be 1 only while tx_busy=0; the non-owner's ready SHALL be 0.
REQ-021 Ready SHALL be a registered/state function and SHALL NOT depend combinationally on valid.
REQ-022 Transfer occurs on owner valid & ready: capture data into tx_data, capture last into a last flag, and go to START.
REQ-023 START SHALL assert tx_start for exactly one cycle, then go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL stay until tx_busy=1, then go to WAIT_DONE.
REQ-025 WAIT_DONE SHALL stay until tx_busy=0.
REQ-026 On leaving WAIT_DONE with the last flag set: go to IDLE, set grant=00 and set last_owner to the current owner.
REQ-027 On leaving WAIT_DONE with the last flag clear: return to OWN with the grant unchanged.
REQ-028 The idle counter SHALL clear on every entry to OWN and increment on each OWN cycle with no transfer.
REQ-029 When the idle counter reaches IDLE_TIMEOUT-1 with no transfer: pulse timeout_err for 1 cycle, set grant=00, set last_owner to the owner, and go to IDLE.
REQ-030 A transfer in the same cycle as counter expiry SHALL win: the byte is accepted and no timeout_err is raised.
REQ-031 The non-owner's valid SHALL be ignored until the grant returns to IDLE.
REQ-032 tx_data SHALL hold its value from capture until the next transfer.
REQ-033 Minimum latency: transfer in cycle N gives tx_start high in cycle N+1.

Reset
REQ-034 While rst=0, asynchronously: state=IDLE; grant=00; req0_ready=req1_ready=0; tx_start=0; tx_data=8'h00; timeout_err=0; last flag=0; idle counter=0; last_owner=requester 1 (so req0 wins the first tie).
REQ-035 Reset asserted mid-frame SHALL abort immediately: no tx_start is issued after release, and any captured byte is discarded.
REQ-036 After rst rises, the first valid is sampled on the first rising clk edge.

Verification
Bench setup: transmitter model raises tx_busy the cycle after tx_start and holds it for 20 cycles; IDLE_TIMEOUT=100.
REQ-037 Single byte: req0 sends 8'h49 with last=1 -> one tx_start with tx_data=8'h49, grant 01 then 00, and req1_ready=0 throughout.
REQ-038 Tie: both valid in IDLE right after reset -> req0 is served first; when both are valid again, req1 is granted next (alternates 01,10,01).
REQ-039 Message lock: req1 sends 8'h41, 8'h42, 8'h43 (last on 8'h43) while req0 stays valid -> three tx_start pulses in order with grant=10 throughout, then req0 is granted.
REQ-040 Timeout: req0 sends 8'h10 with last=0, then drops valid -> timeout_err pulses 100 cycles after re-entering OWN, grant goes 00, and a waiting req1 is granted next.
REQ-041 Reset mid-frame: rst=0 during WAIT_DONE -> all outputs at reset values immediately, and no further tx_start after release.
REQ-042 Expiry collision: a transfer on the exact expiry cycle -> byte transmitted and timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between two byte requesters, the arbiter and a UART transmitter core.
// The slave modport is the arbiter side; master is the requester/transmitter side.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [1:0] grant;
    logic       timeout_err;

    modport slave (
        input  req0_valid,
        input  req0_data,
        input  req0_last,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        input  req1_last,
        output req1_ready,
        output tx_start,
        output tx_data,
        input  tx_busy,
        output grant,
        output timeout_err
    );

    modport master (
        output req0_valid,
        output req0_data,
        output req0_last,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        output req1_last,
        input  req1_ready,
        input  tx_start,
        output tx_busy,
        input  tx_data,
        input  grant,
        input  timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester message arbiter feeding one UART transmitter core.
// An owner keeps the grant until its last byte is sent or it idles out.
module uart_tx_arbiter #(
    parameter int IDLE_TIMEOUT = 52080,
    parameter int CNT_W        = 16
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        OWN,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant_q;
    logic [1:0]       grant_nxt;
    logic             last_owner;
    logic             last_owner_nxt;
    logic             last_flag;
    logic             last_flag_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_nxt;
    logic [7:0]       data_q;
    logic [7:0]       data_nxt;
    logic             tout_q;
    logic             tout_nxt;

    logic             own_valid;
    logic [7:0]       own_data;
    logic             own_last;
    logic             own_ready;
    logic             xfer;
    logic             expire;

    // Owner view of the requester bundle; grant is one-hot inside OWN.
    assign own_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
    assign own_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
    assign own_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;

    assign own_ready = (state == OWN) && !bus.tx_busy;
    assign xfer      = own_ready && own_valid;
    assign expire    = (state == OWN) && !xfer && (idle_cnt == CNT_MAX);

    assign bus.req0_ready  = own_ready && grant_q[0];
    assign bus.req1_ready  = own_ready && grant_q[1];
    assign bus.tx_start    = (state == START);
    assign bus.tx_data     = data_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = tout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_q;
        last_owner_nxt = last_owner;
        last_flag_nxt  = last_flag;
        idle_cnt_nxt   = idle_cnt;
        data_nxt       = data_q;
        tout_nxt       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0_valid &&
                    (!bus.req1_valid || last_owner)) begin
                    grant_nxt    = 2'b01;
                    state_nxt    = OWN;
                    idle_cnt_nxt = '0;
                end else if (bus.req1_valid) begin
                    grant_nxt    = 2'b10;
                    state_nxt    = OWN;
                    idle_cnt_nxt = '0;
                end
            end
            OWN: begin
                // A byte on the expiry cycle takes priority over timeout.
                if (xfer) begin
                    data_nxt      = own_data;
                    last_flag_nxt = own_last;
                    state_nxt     = START;
                end else if (expire) begin
                    tout_nxt       = 1'b1;
                    grant_nxt      = 2'b00;
                    last_owner_nxt = grant_q[1];
                    state_nxt      = IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt + CNT_W'(1);
                end
            end
            START: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_flag) begin
                        grant_nxt      = 2'b00;
                        last_owner_nxt = grant_q[1];
                        state_nxt      = IDLE;
                    end else begin
                        idle_cnt_nxt = '0;
                        state_nxt    = OWN;
                    end
                end
            end
            default: begin
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q    <= 2'b00;
            last_owner <= 1'b1;
            last_flag  <= 1'b0;
            idle_cnt   <= '0;
            data_q     <= 8'h00;
            tout_q     <= 1'b0;
        end else begin
            grant_q    <= grant_nxt;
            last_owner <= last_owner_nxt;
            last_flag  <= last_flag_nxt;
            idle_cnt   <= idle_cnt_nxt;
            data_q     <= data_nxt;
            tout_q     <= tout_nxt;
        end
    end

endmodule
